// File: rtl/add_arbiter_if.sv
// Request/grant, shared-adder and response signals for add_arbiter.
// slave = arbiter side; master = requesters, adder and response consumer.
interface add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] a_in;
  logic [NUM_REQ*DATA_W-1:0] b_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic [DATA_W:0]           add_sum;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W:0]           rsp_sum;
  logic                      rsp_ready;
  logic                      busy;

  modport slave (
    input  req, a_in, b_in, add_sum, rsp_ready,
    output gnt, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy
  );

  modport master (
    output req, a_in, b_in, add_sum, rsp_ready,
    input  gnt, add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder: req in IDLE -> gnt next cycle -> rsp_valid one cycle later.
// Response held stable while rsp_ready is low; no new grants until the response handshake completes.
module add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
) (
  input logic         clk,
  input logic         rst_n,
  add_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_gnt;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     cand;
  logic                found;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [DATA_W-1:0]   add_a_q, add_b_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W:0]     rsp_sum_q;

  // Search upward from last_gnt+1 so the previous winner is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_gnt) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt    <= LAST_RST;
      gnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            add_a_q  <= bus.a_in[int'(winner)*DATA_W +: DATA_W];
            add_b_q  <= bus.b_in[int'(winner)*DATA_W +: DATA_W];
            rsp_id_q <= winner;
            last_gnt <= winner;
            gnt_q    <= NUM_REQ'(1) << winner;
          end
        end
        CALC: begin
          rsp_sum_q   <= bus.add_sum;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: begin
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: vector table of full operations plus multi-cycle corner sequences.
module tb_add_arbiter;
  logic clk;
  logic rst_n;

  add_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .ID_W(2)) bus ();

  // Shared adder instance modelled in the bench.
  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  add_arbiter #(.NUM_REQ(4), .DATA_W(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic [4:0]  exp_sum;
  } vec_t;

  vec_t vecs [12];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation with rsp_ready high; entered and left at a negedge in IDLE.
  task automatic run_op(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus.req       = v.req;
    bus.a_in      = v.a_in;
    bus.b_in      = v.b_in;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, " gnt"}, 32'(bus.gnt), 32'(v.exp_gnt));
    check({tag, " busy_calc"}, 32'(bus.busy), 32'd1);
    bus.req = v.req & ~v.exp_gnt;
    @(negedge clk);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(v.exp_id));
    check({tag, " rsp_sum"}, 32'(bus.rsp_sum), 32'(v.exp_sum));
    check({tag, " gnt_clear"}, 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check({tag, " idle"}, 32'({bus.rsp_valid, bus.busy}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;

    //          req      a_in      b_in      gnt      id     sum
    vecs[0]  = '{4'b0001, 16'h0001, 16'h0005, 4'b0001, 2'd0, 5'd6};
    vecs[1]  = '{4'b1111, 16'hC843, 16'h5A62, 4'b0010, 2'd1, 5'd10};
    vecs[2]  = '{4'b1111, 16'hC843, 16'h5A62, 4'b0100, 2'd2, 5'd18};
    vecs[3]  = '{4'b1111, 16'hC843, 16'h5A62, 4'b1000, 2'd3, 5'd17};
    vecs[4]  = '{4'b1111, 16'hC843, 16'h5A62, 4'b0001, 2'd0, 5'd5};
    vecs[5]  = '{4'b0100, 16'h0F00, 16'h0F00, 4'b0100, 2'd2, 5'd30};
    vecs[6]  = '{4'b1001, 16'hE000, 16'h1000, 4'b1000, 2'd3, 5'd15};
    vecs[7]  = '{4'b0011, 16'h0009, 16'h0007, 4'b0001, 2'd0, 5'd16};
    vecs[8]  = '{4'b0001, 16'h0000, 16'h0000, 4'b0001, 2'd0, 5'd0};
    vecs[9]  = '{4'b0001, 16'h000F, 16'h0001, 4'b0001, 2'd0, 5'd16};
    vecs[10] = '{4'b1010, 16'h0020, 16'h0030, 4'b0010, 2'd1, 5'd5};
    vecs[11] = '{4'b1010, 16'h6000, 16'h7000, 4'b1000, 2'd3, 5'd13};

    rst_n         = 1'b0;
    bus.req       = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset gnt", 32'(bus.gnt), 32'd0);
    check("reset add_ab", 32'({bus.add_a, bus.add_b}), 32'd0);
    check("reset rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no req gnt", 32'({bus.gnt, bus.busy}), 32'd0);

    for (int i = 0; i < 12; i++) run_op(vecs[i], i);

    // Backpressure: pointer is at 3, requester 1 asks with consumer stalled.
    bus.req       = 4'b0010;
    bus.a_in      = 16'h0050;
    bus.b_in      = 16'h0090;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp gnt", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b0000;
    @(negedge clk);
    check("bp rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'({1'b1, 2'd1, 5'd14}));
    bus.req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp stall%0d", c),
            32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.gnt, bus.busy}),
            32'({1'b1, 2'd1, 5'd14, 4'b0000, 1'b1}));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp handshake", 32'({bus.rsp_valid, bus.busy, bus.gnt}), 32'd0);
    @(negedge clk);
    check("bp regrant", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b0000;
    @(negedge clk);
    check("bp regrant rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'({1'b1, 2'd1, 5'd14}));
    @(negedge clk);
    check("bp regrant idle", 32'({bus.rsp_valid, bus.busy}), 32'd0);

    // Operand changes after capture must not reach the result.
    bus.req  = 4'b0001;
    bus.a_in = 16'h0003;
    bus.b_in = 16'h0004;
    @(negedge clk);
    check("opchg gnt", 32'(bus.gnt), 32'b0001);
    bus.a_in = 16'h0004;
    bus.req  = 4'b0000;
    @(negedge clk);
    check("opchg add_a", 32'(bus.add_a), 32'd3);
    check("opchg rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum}), 32'({1'b1, 2'd0, 5'd7}));
    @(negedge clk);

    // Reset during CALC: outputs clear without a clock edge.
    bus.req  = 4'b0100;
    bus.a_in = 16'h0200;
    bus.b_in = 16'h0200;
    @(negedge clk);
    check("rstmid gnt", 32'(bus.gnt), 32'b0100);
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    check("rstmid outputs",
          32'({bus.gnt, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.busy}), 32'd0);
    repeat (2) @(negedge clk);
    check("rstmid held", 32'({bus.rsp_valid, bus.busy}), 32'd0);
    rst_n = 1'b1;
    v = '{4'b1000, 16'h1000, 16'h2000, 4'b1000, 2'd3, 5'd3};
    run_op(v, 100);

    // Reset while stalled in RESP; pointer must return to NUM_REQ-1.
    bus.req       = 4'b0010;
    bus.a_in      = 16'h0010;
    bus.b_in      = 16'h0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    check("rstresp rsp", 32'({bus.rsp_valid, bus.rsp_sum}), 32'({1'b1, 5'd2}));
    rst_n = 1'b0;
    #1;
    check("rstresp clear", 32'({bus.rsp_valid, bus.busy, bus.rsp_sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'b0110, 16'h0330, 16'h0110, 4'b0010, 2'd1, 5'd4};
    run_op(v, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one combinational 4-bit adder (operands a/b, 5-bit sum) among NUM_REQ requesters.
- Grants one requester at a time, drives the adder operands from registers, and captures the sum one cycle later.
- Returns the sum with the requester ID on a valid/ready response channel.
- Sits between requester agents and the shared adder instance on the same clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand width; sum width is DATA_W+1.
- ID_W, 2, width of requester index; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held until gnt seen.
- a_in  input  NUM_REQ*DATA_W  packed operand A; slice i belongs to requester i.
- b_in  input  NUM_REQ*DATA_W  packed operand B; slice i belongs to requester i.
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
- add_a  output  DATA_W  registered operand A to the shared adder.
- add_b  output  DATA_W  registered operand B to the shared adder.
- add_sum  input  DATA_W+1  adder result (combinational from add_a/add_b).
- rsp_valid  output  1  response valid.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_sum  output  DATA_W+1  captured sum.
- rsp_ready  input  1  response consumer ready.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - gnt=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0.
  - state=IDLE.
  - Round-robin pointer last_gnt=NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the winner: first set bit of req searching upward from last_gnt+1, wrapping modulo NUM_REQ.
  - On the clock edge:
    - add_a/add_b <= winner's operand slices.
    - rsp_id <= winner.
    - last_gnt <= winner.
    - gnt <= onehot(winner).
    - state <= CALC.
- CALC (exactly 1 cycle):
  - gnt is high for this cycle only; the requester drops req after seeing gnt.
  - On the edge: rsp_sum <= add_sum, gnt <= 0, rsp_valid <= 1, state <= RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_sum stay stable until rsp_valid&&rsp_ready is sampled.
  - On handshake: rsp_valid <= 0, state <= IDLE.
  - rsp_ready low stalls indefinitely; new req are not granted while in RESP.
- Latency and throughput:
  - req sampled in IDLE -> gnt in the next cycle.
  - rsp_valid one cycle after gnt.
  - Minimum 3 cycles per operation with rsp_ready tied high.
- Arithmetic: rsp_sum = zero-extended a + b, DATA_W+1 bits, no truncation (15+15=30 -> 5'b11110).
- Operands are captured only at the IDLE->CALC edge. Changes to a_in/b_in after that edge do not affect the result.
- Requests that rise while busy are held by the requester and considered at the next IDLE. The arbiter does not latch them.
- Fairness: a continuously requesting set is served strictly in rotation; no requester waits more than NUM_REQ grants.
- Reset mid-operation (any state): all outputs return to reset values immediately (asynchronous). last_gnt returns to NUM_REQ-1. The in-flight result is discarded and no response is produced.
- A single requester repeatedly requesting is granted every operation; the pointer logic must not skip it.
- busy = (state != IDLE).

Test Plan:
- Reset release, req=4'b0001, a_in[0]=1, b_in[0]=5, rsp_ready=1:
  - gnt=4'b0001 one cycle after req is sampled.
  - Next cycle rsp_valid=1, rsp_id=0, rsp_sum=6.
  - Back to IDLE after the handshake.
- req=4'b1111 held continuously, each requester dropping req for one cycle after its gnt then re-raising:
  - Grant order 0,1,2,3,0.
  - Sums match each requester's operands.
- Overflow: a=15, b=15 on requester 2 -> rsp_sum=5'b11110, rsp_id=2.
- Backpressure: rsp_ready=0 for 10 cycles while req=4'b0010 is pending:
  - rsp_valid, rsp_id and rsp_sum stay stable.
  - gnt stays 0 and busy=1.
  - On rsp_ready=1, handshake completes; the next grant goes to requester 1 two cycles later.
- Operand change after capture: a_in[0] changes 3->4 during CALC -> rsp_sum uses 3.
- Reset mid-op: assert rst_n=0 during CALC:
  - Outputs go to 0 immediately.
  - After release with req=4'b1000, the first grant goes to requester 3 and no stale response appears.
